// File: rtl/wf_issue_picker_if.sv
// Bundle between the valid-entry/scoreboard side, the issue picker and the functional unit.
// The pick is offered while pick_valid=1 and is taken in any cycle with fu_ready=1; pick_wfid stays stable until taken or squashed.
interface wf_issue_picker_if #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6
);
    logic [WF_PER_CU-1:0]    valid_entry_in;
    logic [WF_PER_CU-1:0]    ready_entry_in;
    logic                    fu_ready;
    logic                    f_salu_branch_en;
    logic                    f_salu_branch_taken;
    logic [WF_ID_LENGTH-1:0] f_salu_branch_wfid;
    logic                    pick_valid;
    logic [WF_ID_LENGTH-1:0] pick_wfid;
    logic                    issued_valid;
    logic [WF_ID_LENGTH-1:0] issued_wfid;
    logic                    dbg_state;

    modport slave (
        input  valid_entry_in, ready_entry_in, fu_ready,
        input  f_salu_branch_en, f_salu_branch_taken, f_salu_branch_wfid,
        output pick_valid, pick_wfid, issued_valid, issued_wfid, dbg_state
    );

    modport master (
        output valid_entry_in, ready_entry_in, fu_ready,
        output f_salu_branch_en, f_salu_branch_taken, f_salu_branch_wfid,
        input  pick_valid, pick_wfid, issued_valid, issued_wfid, dbg_state
    );
endinterface

// File: rtl/wf_issue_picker.sv
// Round-robin wavefront issue picker with a one-entry hold register.
// A taken SALU branch on the held wavefront drops the pick in place of issuing it.
module wf_issue_picker #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    wf_issue_picker_if.slave   pif
);
    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [WF_ID_LENGTH-1:0] pick_wfid_q, pick_wfid_d;
    logic [WF_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                    pick_valid;
    logic                    br_kill;
    logic                    squash_hold;
    logic                    fire;
    logic [WF_PER_CU-1:0]    cand;
    logic                    found;
    logic [WF_ID_LENGTH-1:0] winner;
    logic                    load;

    assign pick_valid  = (state_q == HOLD);
    assign br_kill     = pif.f_salu_branch_en & pif.f_salu_branch_taken;
    assign squash_hold = br_kill & pick_valid & (pif.f_salu_branch_wfid == pick_wfid_q);
    assign fire        = pick_valid & pif.fu_ready & ~squash_hold;

    // The held wavefront and a just-squashed wavefront are never candidates.
    always_comb begin
        cand = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            cand[i] = pif.valid_entry_in[i] & pif.ready_entry_in[i]
                    & ~(pick_valid & (pick_wfid_q == WF_ID_LENGTH'(i)))
                    & ~(br_kill & (pif.f_salu_branch_wfid == WF_ID_LENGTH'(i)));
        end
    end

    always_comb begin
        int j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = 0; k < WF_PER_CU; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= WF_PER_CU) j = j - WF_PER_CU;
            if (!found && cand[j]) begin
                found  = 1'b1;
                winner = WF_ID_LENGTH'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pick_wfid_d = pick_wfid_q;
        rr_ptr_d    = rr_ptr_q;
        load        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (found) load = 1'b1;
            end
            HOLD: begin
                if (fire || squash_hold) begin
                    if (found) load = 1'b1;
                    else       state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            state_d     = HOLD;
            pick_wfid_d = winner;
            rr_ptr_d    = (winner == WF_ID_LENGTH'(WF_PER_CU - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            pick_wfid_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pick_wfid_q <= pick_wfid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign pif.pick_valid   = pick_valid;
    assign pif.pick_wfid    = pick_wfid_q;
    assign pif.issued_valid = fire;
    assign pif.issued_wfid  = pick_wfid_q;
    assign pif.dbg_state    = logic'(state_q);
endmodule

// File: tb/tb_wf_issue_picker.sv
// Bench for wf_issue_picker: directed scenarios plus a randomized run against a
// distance-from-pointer reference model.
module tb_wf_issue_picker;
    localparam int W  = 40;
    localparam int IW = 6;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bit   m_hold;
    int   m_wfid;
    int   m_rr;

    logic [W-1:0] one;

    wf_issue_picker_if #(.WF_PER_CU(W), .WF_ID_LENGTH(IW)) pif ();

    wf_issue_picker #(.WF_PER_CU(W), .WF_ID_LENGTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner = candidate at the smallest forward distance from the pointer.
    function automatic void model_eval(output bit found, output int w, output bit sq, output bit fr);
        bit brk;
        int bwf;
        int best;
        int d;
        brk  = pif.f_salu_branch_en && pif.f_salu_branch_taken;
        bwf  = int'(pif.f_salu_branch_wfid);
        best = W;
        w    = 0;
        for (int i = 0; i < W; i++) begin
            if (pif.valid_entry_in[i] && pif.ready_entry_in[i]
                && !(m_hold && m_wfid == i) && !(brk && bwf == i)) begin
                d = (i - m_rr + W) % W;
                if (d < best) begin
                    best = d;
                    w    = i;
                end
            end
        end
        found = (best < W);
        sq    = brk && m_hold && (bwf == m_wfid);
        fr    = m_hold && pif.fu_ready && !sq;
    endfunction

    function automatic void model_update();
        bit found, sq, fr;
        int w;
        model_eval(found, w, sq, fr);
        if (!m_hold || fr || sq) begin
            if (found) begin
                m_hold = 1'b1;
                m_wfid = w;
                m_rr   = (w + 1) % W;
            end else begin
                m_hold = 1'b0;
            end
        end
    endfunction

    task automatic drive(input logic [W-1:0] v, input logic [W-1:0] r, input logic fu,
                         input logic en, input logic tk, input int bwf);
        pif.valid_entry_in      = v;
        pif.ready_entry_in      = r;
        pif.fu_ready            = fu;
        pif.f_salu_branch_en    = en;
        pif.f_salu_branch_taken = tk;
        pif.f_salu_branch_wfid  = IW'(bwf);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0, 0);
        m_hold = 1'b0;
        m_wfid = 0;
        m_rr   = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 3);
        m_hold = 1'b0;
        m_wfid = 0;
        m_rr   = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (pif.pick_valid !== 1'b0 || pif.issued_valid !== 1'b0 || pif.pick_wfid !== 6'd0) begin
                failures++;
                $display("FAIL reset_hold: pick_valid=%b issued_valid=%b pick_wfid=%0d want 0/0/0",
                         pif.pick_valid, pif.issued_valid, pif.pick_wfid);
            end
            tick();
        end
        rst = 1'b1;
        drive('0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (pif.pick_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: pick_valid=%b want 0", pif.pick_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq [6] = '{3, 7, 12, 3, 7, 12};
        logic [W-1:0] m;
        do_reset();
        m = (one << 3) | (one << 7) | (one << 12);
        drive(m, m, 1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (pif.pick_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_latency: pick_valid=%b want 0 in candidate cycle", pif.pick_valid);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== IW'(seq[k])
                || pif.issued_valid !== 1'b1 || pif.issued_wfid !== IW'(seq[k])) begin
                failures++;
                $display("FAIL rr_order[%0d]: pv=%b wfid=%0d iv=%b iwfid=%0d want 1/%0d/1/%0d",
                         k, pif.pick_valid, pif.pick_wfid, pif.issued_valid, pif.issued_wfid, seq[k], seq[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int seq [4] = '{38, 39, 0, 39};
        logic [W-1:0] m;
        do_reset();
        drive(one << 38, one << 38, 1'b1, 1'b0, 1'b0, 0);
        tick();
        m = one | (one << 39);
        drive(m, m, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== IW'(seq[k]) || pif.issued_valid !== 1'b1) begin
                failures++;
                $display("FAIL wrap[%0d]: pv=%b wfid=%0d iv=%b want 1/%0d/1",
                         k, pif.pick_valid, pif.pick_wfid, pif.issued_valid, seq[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] m;
        do_reset();
        drive(one << 5, one << 5, 1'b0, 1'b0, 1'b0, 0);
        tick();
        m = (one << 5) | (one << 9);
        drive(m, '0, 1'b0, 1'b0, 1'b0, 0);
        drive(m, m, 1'b0, 1'b0, 1'b0, 0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== 6'd5 || pif.issued_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: pv=%b wfid=%0d iv=%b want 1/5/0",
                         c, pif.pick_valid, pif.pick_wfid, pif.issued_valid);
            end
            tick();
        end
        drive(m, m, 1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (pif.issued_valid !== 1'b1 || pif.issued_wfid !== 6'd5) begin
            failures++;
            $display("FAIL bp_release: iv=%b iwfid=%0d want 1/5", pif.issued_valid, pif.issued_wfid);
        end
        tick();
        checks++;
        if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== 6'd9) begin
            failures++;
            $display("FAIL bp_next: pv=%b wfid=%0d want 1/9", pif.pick_valid, pif.pick_wfid);
        end
    endtask

    task automatic test_squash();
        logic [W-1:0] m;
        do_reset();
        drive(one << 5, one << 5, 1'b0, 1'b0, 1'b0, 0);
        tick();
        m = (one << 5) | (one << 9);
        drive(m, m, 1'b1, 1'b1, 1'b1, 5);
        checks++;
        if (pif.issued_valid !== 1'b0 || pif.pick_valid !== 1'b1) begin
            failures++;
            $display("FAIL squash_pulse: iv=%b pv=%b want 0/1", pif.issued_valid, pif.pick_valid);
        end
        tick();
        checks++;
        if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== 6'd9) begin
            failures++;
            $display("FAIL squash_next: pv=%b wfid=%0d want 1/9", pif.pick_valid, pif.pick_wfid);
        end
        drive('0, '0, 1'b1, 1'b1, 1'b1, 9);
        checks++;
        if (pif.issued_valid !== 1'b0) begin
            failures++;
            $display("FAIL squash_prio: iv=%b want 0", pif.issued_valid);
        end
        tick();
        checks++;
        if (pif.pick_valid !== 1'b0) begin
            failures++;
            $display("FAIL squash_empty: pv=%b want 0", pif.pick_valid);
        end
        drive(one << 20, one << 20, 1'b0, 1'b1, 1'b0, 20);
        tick();
        drive('0, '0, 1'b1, 1'b1, 1'b0, 20);
        checks++;
        if (pif.issued_valid !== 1'b1 || pif.issued_wfid !== 6'd20) begin
            failures++;
            $display("FAIL not_taken: iv=%b iwfid=%0d want 1/20", pif.issued_valid, pif.issued_wfid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(one << 17, one << 17, 1'b0, 1'b0, 1'b0, 0);
        tick();
        checks++;
        if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== 6'd17) begin
            failures++;
            $display("FAIL areset_pre: pv=%b wfid=%0d want 1/17", pif.pick_valid, pif.pick_wfid);
        end
        #2;
        rst = 1'b0;
        #1;
        m_hold = 1'b0;
        m_wfid = 0;
        m_rr   = 0;
        checks++;
        if (pif.pick_valid !== 1'b0 || pif.issued_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_drop: pv=%b iv=%b want 0/0", pif.pick_valid, pif.issued_valid);
        end
        #2;
        rst = 1'b1;
        tick();
        checks++;
        if (pif.pick_valid !== 1'b1 || pif.pick_wfid !== 6'd17) begin
            failures++;
            $display("FAIL areset_repick: pv=%b wfid=%0d want 1/17", pif.pick_valid, pif.pick_wfid);
        end
    endtask

    task automatic test_random();
        bit found, sq, fr;
        int w;
        int bwf;
        logic [W-1:0] v, r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v   = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            r   = {$urandom, $urandom} | {$urandom, $urandom};
            bwf = ($urandom_range(0, 1) == 1 && m_hold) ? m_wfid : int'($urandom_range(0, W - 1));
            drive(v, r, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 1)), bwf);
            model_eval(found, w, sq, fr);
            checks++;
            if (pif.pick_valid !== logic'(m_hold) || (m_hold && pif.pick_wfid !== IW'(m_wfid))) begin
                failures++;
                $display("FAIL rand_pick[%0d]: pv=%b wfid=%0d want %b/%0d",
                         c, pif.pick_valid, pif.pick_wfid, m_hold, m_wfid);
            end
            checks++;
            if (pif.issued_valid !== logic'(fr) || (fr && pif.issued_wfid !== IW'(m_wfid))) begin
                failures++;
                $display("FAIL rand_issue[%0d]: iv=%b iwfid=%0d want %b/%0d",
                         c, pif.issued_valid, pif.issued_wfid, fr, m_wfid);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        one      = 1;
        m_hold   = 1'b0;
        m_wfid   = 0;
        m_rr     = 0;
        rst      = 1'b1;
        drive('0, '0, 1'b0, 1'b0, 1'b0, 0);
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_squash();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
